mem_stage_ctrl: RTL and testbench

- Parametrised memory-stage controller between the pipeline's memory stage and a multi-cycle data memory system with a Done/Stall interface.
- Captures one load/store request, holds address and data stable, and re-presents the request while memory signals busy.
- Waits for completion, returns read data, and stalls the pipeline until then.
- Also provides immediate bypass for load-immediate, alignment/conflict/timeout error detection, and a saturating stall-cycle counter.

---
 rtl/mem_stage_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: captures one load/store from the pipeline, holds it
// stable towards a multi-cycle memory with a done/stall handshake, stalls the
// pipeline until completion and returns the load result for one cycle.
// Also handles load-immediate bypass, request/memory/timeout error reporting
// and a saturating count of pipeline stall cycles.
module mem_stage_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int TIMEOUT   = 64,
    parameter int ALIGN_CHK = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              bypass,
    input  logic [DATA_W-1:0] bypass_data,
    output logic              stall_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic              valid_out,
    output logic              err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    input  logic              mem_stall,
    input  logic              mem_err
);

    // Timeout counter must be able to hold TIMEOUT-1.
    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Odd addresses are only rejected when the alignment check is enabled.
    function automatic logic addr_misaligned(input logic [ADDR_W-1:0] addr);
        return (ALIGN_CHK != 0) && addr[0];
    endfunction

    state_t            state_q, state_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              op_rd_q, op_rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;

    logic              misaligned_s;
    logic              req_ok_s;
    logic              req_bad_s;
    logic              stall_s;

    // Classify the incoming pipeline request (bypass overrides everything).
    always_comb begin
        misaligned_s = addr_misaligned(req_addr);
        req_ok_s     = ~bypass & (req_rd ^ req_wr) & ~misaligned_s;
        req_bad_s    = ~bypass & ((req_rd & req_wr) |
                                  ((req_rd | req_wr) & misaligned_s));
    end

    // Next-state and datapath update for the IDLE/BUSY/RESP sequence.
    always_comb begin
        state_d  = state_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        op_rd_d  = op_rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        tmo_d    = tmo_q;
        stall_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bypass) begin
                    // Immediate value is shown and remembered as the last result.
                    rdata_d = bypass_data;
                end else if (req_ok_s) begin
                    stall_s  = 1'b1;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    op_rd_d  = req_rd;
                    mem_rd_d = req_rd;
                    mem_wr_d = req_wr;
                    tmo_d    = {TO_W{1'b0}};
                    state_d  = ST_BUSY;
                end else if (req_bad_s) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUSY: begin
                stall_s = 1'b1;
                if (mem_err) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end

                if (mem_done) begin
                    // Completion wins over a simultaneous timeout.
                    if (op_rd_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = ST_RESP;
                end else if (tmo_q == TO_LAST) begin
                    err_d    = 1'b1;
                    rdata_d  = {DATA_W{1'b0}};
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                    if ((mem_rd_q | mem_wr_q) && !mem_stall) begin
                        // Request accepted this cycle; withdraw it next cycle.
                        mem_rd_d = 1'b0;
                        mem_wr_d = 1'b0;
                    end else begin
                        mem_rd_d = mem_rd_q;
                        mem_wr_d = mem_wr_q;
                    end
                end
            end

            ST_RESP: begin
                // Request inputs still belong to the completed instruction.
                state_d = ST_IDLE;
            end

            default: begin
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Saturating count of cycles in which the pipeline is held.
    always_comb begin
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            op_rd_q     <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            tmo_q       <= {TO_W{1'b0}};
        end else begin
            state_q     <= state_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            op_rd_q     <= op_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    // Output drive: stall and bypass data must act within the request cycle.
    always_comb begin
        stall_out = stall_s;
        if ((state_q == ST_IDLE) && bypass) begin
            rdata_out = bypass_data;
        end else begin
            rdata_out = rdata_q;
        end
        valid_out = valid_q;
        err       = err_q;
        stall_cnt = stall_cnt_q;
        mem_rd    = mem_rd_q;
        mem_wr    = mem_wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd, req_wr;
    logic [15:0] req_addr, req_wdata;
    logic        bypass;
    logic [15:0] bypass_data;
    logic        stall_out;
    logic [15:0] rdata_out;
    logic        valid_out;
    logic        err;
    logic [15:0] stall_cnt;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done, mem_stall, mem_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_model = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          n_stall;
        int          done_dly;
        logic [15:0] mrdata;
        logic [15:0] exp_rdata;
        int          exp_stall;
    } vec_t;

    vec_t vecs[6];

    mem_stage_ctrl #(
        .DATA_W(16), .ADDR_W(16), .TIMEOUT(64), .ALIGN_CHK(1), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .bypass(bypass), .bypass_data(bypass_data),
        .stall_out(stall_out), .rdata_out(rdata_out), .valid_out(valid_out),
        .err(err), .stall_cnt(stall_cnt),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every completion pops the oldest expected result.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_valid: got rdata 0x%0h, expected no completion", rdata_out);
            end else begin
                check("sb_rdata", rdata_out, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cnt_model = 0;
    endtask

    task automatic run_txn(input vec_t v);
        int last_k;
        req_rd = v.rd; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata; bypass = 1'b0;
        sb_q.push_back(v.exp_rdata);
        @(negedge clk);
        check("req_stall", stall_out, 1);
        tick();
        req_rd = 1'b0; req_wr = 1'b0;
        req_addr = 16'($urandom); req_wdata = 16'($urandom);
        last_k = v.n_stall + v.done_dly;
        for (int k = 0; k <= last_k; k++) begin
            mem_stall = (k < v.n_stall);
            mem_done  = (k == last_k);
            mem_rdata = (k == last_k) ? v.mrdata : 16'($urandom);
            @(negedge clk);
            check("busy_stall", stall_out, 1);
            check("busy_mem_rd", mem_rd, (k <= v.n_stall) ? v.rd : 1'b0);
            check("busy_mem_wr", mem_wr, (k <= v.n_stall) ? v.wr : 1'b0);
            check("busy_addr", mem_addr, v.addr);
            check("busy_wdata", mem_wdata, v.wdata);
            tick();
        end
        mem_stall = 1'b0; mem_done = 1'b0;
        req_rd = 1'b1; req_addr = 16'h0004;
        @(negedge clk);
        check("resp_valid", valid_out, 1);
        check("resp_stall", stall_out, 0);
        cnt_model += v.exp_stall;
        check("resp_stall_cnt", stall_cnt, cnt_model);
        tick();
        req_rd = 1'b0;
        @(negedge clk);
        check("resp_req_ignored", mem_rd, 0);
        check("post_stall", stall_out, 0);
        check("post_valid", valid_out, 0);
        tick();
    endtask

    initial begin
        rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
        bypass = 1'b0; bypass_data = 16'h0000; mem_rdata = 16'h0000;
        mem_done = 1'b0; mem_stall = 1'b0; mem_err = 1'b0;

        //            rd    wr    addr      wdata     st dly mrdata    exp_rdata exp_stall
        vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF, 16'hBEEF, 2};
        vecs[1] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 3, 2, 16'hDEAD, 16'hBEEF, 7};
        vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1, 0, 16'h5A5A, 16'h5A5A, 3};
        vecs[3] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 0, 4, 16'h0001, 16'h0001, 6};
        vecs[4] = '{1'b0, 1'b1, 16'h8000, 16'hFFFF, 2, 0, 16'h7777, 16'h0001, 4};
        vecs[5] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 0, 1, 16'hC3C3, 16'hC3C3, 3};

        do_reset();
        @(negedge clk);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", rdata_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_err", err, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_stall", stall_out, 0);
        tick();

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i]);
        end
        check("txn_err", err, 0);

        // Bypass with a concurrent load request.
        bypass = 1'b1; bypass_data = 16'h00A5; req_rd = 1'b1; req_addr = 16'h0010;
        @(negedge clk);
        check("byp_rdata", rdata_out, 16'h00A5);
        check("byp_stall", stall_out, 0);
        check("byp_valid", valid_out, 0);
        tick();
        bypass = 1'b0; req_rd = 1'b0;
        @(negedge clk);
        check("byp_mem_rd", mem_rd, 0);
        check("byp_valid2", valid_out, 0);
        tick();

        // Timeout: the memory accepts but never completes.
        req_rd = 1'b1; req_addr = 16'h0040;
        sb_q.push_back(16'h0000);
        tick();
        req_rd = 1'b0;
        for (int k = 0; k < 64; k++) begin
            mem_rdata = 16'($urandom);
            @(negedge clk);
            check("tmo_mem_rd", mem_rd, (k == 0) ? 1'b1 : 1'b0);
            check("tmo_stall", stall_out, 1);
            check("tmo_err_early", err, 0);
            tick();
        end
        @(negedge clk);
        check("tmo_valid", valid_out, 1);
        check("tmo_err", err, 1);
        check("tmo_rdata", rdata_out, 0);
        check("tmo_stall_cnt", stall_cnt, cnt_model + 65);
        tick();
        mem_done = 1'b1; mem_rdata = 16'h9999;
        tick();
        mem_done = 1'b0;
        @(negedge clk);
        check("late_done_valid", valid_out, 0);
        check("late_done_rdata", rdata_out, 0);
        tick();

        // Reset while an access is outstanding (held off by mem_stall).
        req_rd = 1'b1; req_addr = 16'h0030;
        tick();
        req_rd = 1'b0; mem_stall = 1'b1;
        @(negedge clk);
        check("pre_rst_mem_rd", mem_rd, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_stall = 1'b0; cnt_model = 0;
        @(negedge clk);
        check("busy_rst_mem_rd", mem_rd, 0);
        check("busy_rst_stall", stall_out, 0);
        check("busy_rst_err", err, 0);
        check("busy_rst_cnt", stall_cnt, 0);
        tick();
        @(negedge clk);
        check("busy_rst_no_valid", valid_out, 0);
        tick();
        run_txn(vecs[0]);

        // Misaligned load on a clean error flag.
        req_rd = 1'b1; req_addr = 16'h0003;
        @(negedge clk);
        check("mis_stall", stall_out, 0);
        tick();
        req_rd = 1'b0;
        @(negedge clk);
        check("mis_mem_rd", mem_rd, 0);
        check("mis_err", err, 1);
        tick();

        // Conflicting load+store, then misaligned: error stays set, no access.
        do_reset();
        req_rd = 1'b1; req_wr = 1'b1; req_addr = 16'h0010;
        @(negedge clk);
        check("conf_stall", stall_out, 0);
        tick();
        req_rd = 1'b0; req_wr = 1'b0;
        @(negedge clk);
        check("conf_err", err, 1);
        check("conf_mem_rd", mem_rd, 0);
        check("conf_mem_wr", mem_wr, 0);
        tick();
        req_wr = 1'b1; req_addr = 16'h0003;
        @(negedge clk);
        check("mis2_stall", stall_out, 0);
        tick();
        req_wr = 1'b0;
        @(negedge clk);
        check("mis2_mem_wr", mem_wr, 0);
        check("mis2_err", err, 1);
        tick();

        // Memory-side error: flagged, but the access still completes.
        do_reset();
        req_rd = 1'b1; req_addr = 16'h0050;
        sb_q.push_back(16'h4321);
        tick();
        req_rd = 1'b0; mem_err = 1'b1; mem_done = 1'b1; mem_rdata = 16'h4321;
        tick();
        mem_err = 1'b0; mem_done = 1'b0;
        @(negedge clk);
        check("merr_valid", valid_out, 1);
        check("merr_err", err, 1);
        tick();
        tick();

        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
